// File: rtl/cla_pkg.sv
// Shared definitions for the 16-bit carry-lookahead subtractor:
// group sizing, the {G,P} pair type and per-group helper functions.
package cla_pkg;

  localparam int CLA_GROUP_WIDTH = 4;
  localparam int CLA_GROUPS      = 4;

  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;

  // Group generate/propagate of a 4-bit slice.
  function automatic cla_gp_t cla_group_gp(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] g;
    logic [3:0] p;
    cla_gp_t    r;
    g   = a & b;
    p   = a ^ b;
    r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    r.p = &p;
    return r;
  endfunction

  // Sum of a 4-bit slice given the group carry-in from the lookahead unit.
  function automatic logic [3:0] cla_group_sum(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    for (int i = 0; i < 3; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return p ^ c;
  endfunction

endpackage

// File: rtl/cla_subtractor16_pipe_clu.sv
// Second-level carry-lookahead unit: four group {G,P} pairs plus a carry-in
// produce the group boundary carries and the block-level G/P.
module carry_lookahead_unit4
  import cla_pkg::*;
(
  input  cla_gp_t [3:0] i_gp,
  input  logic          i_carry,
  output logic          o_c4,
  output logic          o_c8,
  output logic          o_c12,
  output logic          o_c16,
  output logic          o_group_generation,
  output logic          o_group_propagation
);

  // Flat lookahead equations for every group boundary.
  always_comb begin
    o_c4  = i_gp[0].g | (i_gp[0].p & i_carry);
    o_c8  = i_gp[1].g | (i_gp[1].p & i_gp[0].g) | (i_gp[1].p & i_gp[0].p & i_carry);
    o_c12 = i_gp[2].g | (i_gp[2].p & i_gp[1].g) | (i_gp[2].p & i_gp[1].p & i_gp[0].g)
          | (i_gp[2].p & i_gp[1].p & i_gp[0].p & i_carry);
    o_group_generation  = i_gp[3].g | (i_gp[3].p & i_gp[2].g)
                        | (i_gp[3].p & i_gp[2].p & i_gp[1].g)
                        | (i_gp[3].p & i_gp[2].p & i_gp[1].p & i_gp[0].g);
    o_group_propagation = i_gp[3].p & i_gp[2].p & i_gp[1].p & i_gp[0].p;
    o_c16 = o_group_generation | (o_group_propagation & i_carry);
  end

endmodule

// File: rtl/cla_subtractor16_pipe.sv
// Streaming 16-bit subtractor: Output = InputA - InputB - InputBorrow, built as
// A + ~B + ~borrow through four CLA groups and a second-level lookahead unit.
// Build option CLA_SUB_MID_PIPE_EN: split at c8 into two stages (latency 2,
// capacity 2); otherwise a single registered stage (latency 1, capacity 1).
module cla_subtractor16_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             InputBorrow,
  input  logic             InputValid,
  output logic             InputReady,
  output logic [WIDTH-1:0] Output,
  output logic             OutputBorrow,
  output logic             OutputZero,
  output logic             OutputOverflow,
  output logic             OutputValid,
  input  logic             OutputReady
);

  logic [WIDTH-1:0]         w_b_n;
  logic                     w_c0;
  cla_gp_t [CLA_GROUPS-1:0] w_gp;
  logic                     w_c4, w_c8, w_c12, w_c16, w_grp_g, w_grp_p;

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow, r_zero, r_ovf, r_valid;

  assign w_b_n = ~InputB;
  assign w_c0  = ~InputBorrow;

  for (genvar g = 0; g < CLA_GROUPS; g++) begin : g_group
    assign w_gp[g] = cla_group_gp(InputA[g*CLA_GROUP_WIDTH +: CLA_GROUP_WIDTH],
                                  w_b_n[g*CLA_GROUP_WIDTH +: CLA_GROUP_WIDTH]);
  end

  carry_lookahead_unit4 u_clu (
    .i_gp                (w_gp),
    .i_carry             (w_c0),
    .o_c4                (w_c4),
    .o_c8                (w_c8),
    .o_c12               (w_c12),
    .o_c16               (w_c16),
    .o_group_generation  (w_grp_g),
    .o_group_propagation (w_grp_p)
  );

`ifdef CLA_SUB_MID_PIPE_EN
  // Upper lookahead is recomputed in stage 2 from the registered c8.
  logic       w_unused;
  logic [7:0] w_lo_diff;
  logic       r1_valid, r1_c8;
  logic [7:0] r1_lo, r1_a_hi, r1_bn_hi;
  logic       w_s1_adv, w_s2_adv;
  cla_gp_t    w_gp2, w_gp3;
  logic       w_s2_c12, w_s2_c16;
  logic [WIDTH-1:0] w_diff;

  assign w_unused  = ^{w_c12, w_c16, w_grp_g, w_grp_p, w_gp[2], w_gp[3]};
  assign w_lo_diff = {cla_group_sum(InputA[7:4], w_b_n[7:4], w_c4),
                      cla_group_sum(InputA[3:0], w_b_n[3:0], w_c0)};

  assign w_s2_adv   = ~r_valid | OutputReady;
  assign w_s1_adv   = ~r1_valid | w_s2_adv;
  assign InputReady = w_s1_adv;

  // Stage 1 valid: refilled from upstream whenever stage 1 advances.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)       r1_valid <= 1'b0;
    else if (w_s1_adv) r1_valid <= InputValid;
  end

  // Stage 1 data: low byte result, c8 and the untouched upper operands.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r1_lo    <= '0;
      r1_c8    <= 1'b0;
      r1_a_hi  <= '0;
      r1_bn_hi <= '0;
    end else if (InputValid && w_s1_adv) begin
      r1_lo    <= w_lo_diff;
      r1_c8    <= w_c8;
      r1_a_hi  <= InputA[15:8];
      r1_bn_hi <= w_b_n[15:8];
    end
  end

  // Stage 2 combinational: upper two groups resolved from the registered c8.
  always_comb begin
    w_gp2    = cla_group_gp(r1_a_hi[3:0], r1_bn_hi[3:0]);
    w_gp3    = cla_group_gp(r1_a_hi[7:4], r1_bn_hi[7:4]);
    w_s2_c12 = w_gp2.g | (w_gp2.p & r1_c8);
    w_s2_c16 = w_gp3.g | (w_gp3.p & w_s2_c12);
    w_diff   = {cla_group_sum(r1_a_hi[7:4], r1_bn_hi[7:4], w_s2_c12),
                cla_group_sum(r1_a_hi[3:0], r1_bn_hi[3:0], r1_c8),
                r1_lo};
  end

  // Stage 2 valid: takes stage 1 contents whenever the output slot frees up.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)       r_valid <= 1'b0;
    else if (w_s2_adv) r_valid <= r1_valid;
  end

  // Stage 2 data: final difference and status flags; held while stalled.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r1_valid && w_s2_adv) begin
      r_diff   <= w_diff;
      r_borrow <= ~w_s2_c16;
      r_zero   <= (w_diff == '0);
      r_ovf    <= (r1_a_hi[7] ^ ~r1_bn_hi[7]) & (w_diff[15] ^ r1_a_hi[7]);
    end
  end
`else
  logic             w_unused;
  logic             w_adv;
  logic [WIDTH-1:0] w_diff;

  assign w_unused = ^{w_c12 & 1'b0, w_grp_g, w_grp_p};
  assign w_diff   = {cla_group_sum(InputA[15:12], w_b_n[15:12], w_c12),
                     cla_group_sum(InputA[11:8],  w_b_n[11:8],  w_c8),
                     cla_group_sum(InputA[7:4],   w_b_n[7:4],   w_c4),
                     cla_group_sum(InputA[3:0],   w_b_n[3:0],   w_c0)};

  assign w_adv      = ~r_valid | OutputReady;
  assign InputReady = w_adv;

  // Output valid: refilled from upstream whenever the single stage advances.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)    r_valid <= 1'b0;
    else if (w_adv) r_valid <= InputValid;
  end

  // Output data: full-width result and flags; held while stalled.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (InputValid && w_adv) begin
      r_diff   <= w_diff;
      r_borrow <= ~w_c16;
      r_zero   <= (w_diff == '0);
      r_ovf    <= (InputA[15] ^ InputB[15]) & (w_diff[15] ^ InputA[15]);
    end
  end
`endif

  assign Output         = r_diff;
  assign OutputBorrow   = r_borrow;
  assign OutputZero     = r_zero;
  assign OutputOverflow = r_ovf;
  assign OutputValid    = r_valid;

endmodule

// File: tb/tb_cla_subtractor16_pipe.sv
// Self-checking bench for cla_subtractor16_pipe (both builds of CLA_SUB_MID_PIPE_EN).
module tb_cla_subtractor16_pipe;

`ifdef CLA_SUB_MID_PIPE_EN
  localparam int LAT = 2;
  localparam int CAP = 2;
`else
  localparam int LAT = 1;
  localparam int CAP = 1;
`endif

  logic        Clock = 1'b0;
  logic        ResetN;
  logic [15:0] InputA, InputB;
  logic        InputBorrow, InputValid, InputReady;
  logic [15:0] Output;
  logic        OutputBorrow, OutputZero, OutputOverflow, OutputValid, OutputReady;

  typedef struct packed {
    logic [15:0] d;
    logic        b;
    logic        z;
    logic        v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  cla_subtractor16_pipe #(.WIDTH(16)) dut (
    .Clock          (Clock),
    .ResetN         (ResetN),
    .InputA         (InputA),
    .InputB         (InputB),
    .InputBorrow    (InputBorrow),
    .InputValid     (InputValid),
    .InputReady     (InputReady),
    .Output         (Output),
    .OutputBorrow   (OutputBorrow),
    .OutputZero     (OutputZero),
    .OutputOverflow (OutputOverflow),
    .OutputValid    (OutputValid),
    .OutputReady    (OutputReady)
  );

  always #5 Clock = ~Clock;

  // Reference: plain 17-bit subtraction; overflow uses the operand/result sign rule.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
    logic [16:0] r;
    exp_t        e;
    r   = {1'b0, a} - {1'b0, b} - {16'b0, bi};
    e.d = r[15:0];
    e.b = r[16];
    e.z = (r[15:0] == 16'h0000);
    e.v = (a[15] ^ b[15]) & (r[15] ^ a[15]);
    return e;
  endfunction

  // Scoreboard: every output transfer is matched against the oldest expectation.
  always @(negedge Clock) begin
    if (ResetN && OutputValid && OutputReady) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: got %h b%0d z%0d v%0d, required no output",
                 Output, OutputBorrow, OutputZero, OutputOverflow);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({Output, OutputBorrow, OutputZero, OutputOverflow} !== {e.d, e.b, e.z, e.v}) begin
          n_fail++;
          $display("FAIL scoreboard_result: got %h b%0d z%0d v%0d, required %h b%0d z%0d v%0d",
                   Output, OutputBorrow, OutputZero, OutputOverflow, e.d, e.b, e.z, e.v);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bi);
    int k;
    InputA = a; InputB = b; InputBorrow = bi; InputValid = 1'b1;
    k = 0;
    @(negedge Clock);
    while (!InputReady && k < 50) begin
      @(negedge Clock);
      k++;
    end
    if (!InputReady) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: InputReady=%0d after %0d cycles, required 1", InputReady, k);
    end else begin
      q.push_back(model(a, b, bi));
    end
    @(posedge Clock); #1;
    InputValid = 1'b0;
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(posedge Clock); #1;
      k++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic test_reset;
    #2;
    n_tests++;
    if ({Output, OutputBorrow, OutputZero, OutputOverflow, OutputValid} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h %b%b%b%b, required 0000 0000",
               Output, OutputBorrow, OutputZero, OutputOverflow, OutputValid);
    end
    @(posedge Clock); #1;
    ResetN = 1'b1;
    @(negedge Clock);
    n_tests++;
    if (InputReady !== 1'b1 || OutputValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got ready=%0d valid=%0d, required ready=1 valid=0",
               InputReady, OutputValid);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_vectors;
    OutputReady = 1'b1;
    send(16'h0000, 16'h0001, 1'b0);
    send(16'h1234, 16'h1234, 1'b0);
    send(16'h1234, 16'h1234, 1'b1);
    send(16'h8000, 16'h0001, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h0000, 16'h0000, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom));
    end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b;
    logic        bi;
    OutputReady = 1'b1;
    for (int i = 0; i < 9 + LAT; i++) begin
      if (i < 8) begin
        a = 16'($urandom); b = 16'($urandom); bi = 1'($urandom);
        InputA = a; InputB = b; InputBorrow = bi; InputValid = 1'b1;
      end else begin
        InputValid = 1'b0;
      end
      @(negedge Clock);
      n_tests++;
      if (OutputValid !== ((i >= LAT) && (i < 8 + LAT))) begin
        n_fail++;
        $display("FAIL b2b_valid: cycle %0d OutputValid=%0d, required %0d",
                 i, OutputValid, ((i >= LAT) && (i < 8 + LAT)));
      end
      if (i < 8) begin
        n_tests++;
        if (InputReady !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready: cycle %0d InputReady=%0d, required 1", i, InputReady);
        end else begin
          q.push_back(model(a, b, bi));
        end
      end
      @(posedge Clock); #1;
    end
    drain();
  endtask

  task automatic test_backpressure;
    logic [15:0] va[4];
    logic [15:0] vb[4];
    logic        vbi[4];
    int          idx, occ, j;
    logic        saw_block, prev_stall, exp_ready, acc, xfer;
    logic [19:0] held;
    va[0] = 16'h0100; vb[0] = 16'h0001; vbi[0] = 1'b0;
    va[1] = 16'h8000; vb[1] = 16'h7FFF; vbi[1] = 1'b1;
    va[2] = 16'h0005; vb[2] = 16'h0009; vbi[2] = 1'b0;
    va[3] = 16'hABCD; vb[3] = 16'h1111; vbi[3] = 1'b1;
    idx = 0; occ = 0; j = 0;
    saw_block = 1'b0; prev_stall = 1'b0; held = '0;
    while ((idx < 4 || q.size() != 0) && j < 40) begin
      OutputReady = !(j >= 2 && j < 5);
      InputValid  = (idx < 4);
      if (idx < 4) begin
        InputA = va[idx]; InputB = vb[idx]; InputBorrow = vbi[idx];
      end
      @(negedge Clock);
      exp_ready = (occ < CAP) || OutputReady;
      if (InputValid) begin
        n_tests++;
        if (InputReady !== exp_ready) begin
          n_fail++;
          $display("FAIL bp_ready: cycle %0d InputReady=%0d, required %0d", j, InputReady, exp_ready);
        end
      end
      if (InputReady === 1'b0) saw_block = 1'b1;
      if (prev_stall) begin
        n_tests++;
        if ({OutputValid, Output, OutputBorrow, OutputZero, OutputOverflow} !== held) begin
          n_fail++;
          $display("FAIL bp_hold: cycle %0d got %h, required %h", j,
                   {OutputValid, Output, OutputBorrow, OutputZero, OutputOverflow}, held);
        end
      end
      prev_stall = OutputValid && !OutputReady;
      held = {OutputValid, Output, OutputBorrow, OutputZero, OutputOverflow};
      acc  = InputValid && InputReady;
      xfer = OutputValid && OutputReady;
      if (acc) begin
        q.push_back(model(va[idx], vb[idx], vbi[idx]));
        idx++;
      end
      occ = occ + int'(acc) - int'(xfer);
      @(posedge Clock); #1;
      j++;
    end
    InputValid  = 1'b0;
    OutputReady = 1'b1;
    n_tests++;
    if (idx != 4 || q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_complete: accepted %0d outstanding %0d, required 4 and 0", idx, q.size());
    end
    n_tests++;
    if (!saw_block) begin
      n_fail++;
      $display("FAIL bp_block: InputReady never dropped, required a drop at capacity");
    end
  endtask

  task automatic test_reset_midstream;
    logic stale;
    OutputReady = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      send(16'h0000, 16'h0001 + 16'(i), 1'b0);
    end
    @(negedge Clock);
    n_tests++;
    if (OutputValid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_inflight: OutputValid=%0d, required 1", OutputValid);
    end
    #2;
    ResetN = 1'b0;
    #1;
    n_tests++;
    if ({Output, OutputBorrow, OutputZero, OutputOverflow, OutputValid} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h %b%b%b%b, required 0000 0000",
               Output, OutputBorrow, OutputZero, OutputOverflow, OutputValid);
    end
    q.delete();
    @(posedge Clock); #3;
    ResetN = 1'b1;
    @(negedge Clock);
    n_tests++;
    if (InputReady !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_ready: InputReady=%0d, required 1", InputReady);
    end
    OutputReady = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (OutputValid !== 1'b0) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL rst_mid_stale: OutputValid seen 1 after reset, required 0");
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN      = 1'b0;
    InputA      = '0;
    InputB      = '0;
    InputBorrow = 1'b0;
    InputValid  = 1'b0;
    OutputReady = 1'b1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
